coin_collector: RTL and testbench
=================================

// Module: coin_collector
// PURPOSE
//  Upstream feeder of the score counter. Once per video frame, scans a fixed table of
//  coin positions against the player box and marks every overlapping, uncollected
//  coin as collected. Queues credits and drives C_up high for one frame per credit.
//  The score counter samples C_up on each frame_clk rising edge.
//  Also exports per-coin visibility to the sprite drawer.
// PARAMETERS
//  NUM_COINS  16  coins in the table (1..32)
//  COIN_HALF  4   coin half-size in pixels
//  PEND_W     4   width of the pending-credit counter (saturates at 2**PEND_W-1)
// PORTS
//  Clk            in   1          system clock (single clock domain)
//  Reset          in   1          asynchronous, active-low reset
//  frame_clk      in   1          frame strobe level, resynchronised internally
//  clr            in   1          level restart: restore all coins, drop pending credits
//  Ball_X         in   10         player centre X (pixels)
//  Ball_Y         in   10         player centre Y (pixels)
//  Ball_Size      in   10         player half-size (pixels)
//  C_up           out  1          score increment request, held for one whole frame
//  coin_visible   out  NUM_COINS  1 = coin i not yet collected
//  all_collected  out  1          1 = every coin collected
//  busy           out  1          1 while scanning
// BEHAVIOUR
//  Reset (async, Reset=0): C_up=0, coin_visible=all 1s, all_collected=0, busy=0.
//    pending=0, FSM=IDLE, sync flops=0.
//  frame_tick: 2-flop synchroniser on frame_clk plus rising-edge detect; 1-Clk pulse.
//  FSM IDLE -> SCAN -> REPORT -> IDLE.
//   IDLE: on frame_tick:
//    - pending <= pending - C_up; credit consumed at the edge the counter just sampled.
//    - C_up <= 0; latch Ball_X/Ball_Y/Ball_Size snapshot; idx <= 0; go to SCAN.
//   SCAN: one coin per Clk, idx 0..NUM_COINS-1; ROM read has 1-cycle latency.
//    Hit when coin_visible[idx]=1, |Ball_X-cx| < Ball_Size+COIN_HALF
//    and |Ball_Y-cy| < Ball_Size+COIN_HALF.
//    Differences use 11-bit signed arithmetic; no wrap on the 10-bit coordinates.
//    On a hit: coin_visible[idx] <= 0; pending <= sat(pending+1).
//    After the last idx, go to REPORT. busy=1 throughout SCAN.
//   REPORT (1 Clk): C_up <= (pending != 0); go to IDLE.
//  Timing and credits:
//   - Scan length NUM_COINS+2 Clk, far below one frame period.
//   - C_up is stable for roughly the whole frame before the next edge.
//   - Several hits in one frame give one credit per subsequent frame, never lost
//     below saturation.
//   - At saturation, extra hits still remove the coin but add no credit.
//  all_collected = (coin_visible == 0), registered, updated in the cycle after SCAN ends.
//  clr is synchronous, with priority over frame_tick and scan.
//   - Aborts a scan mid-way: FSM=IDLE, C_up=0, pending=0, coin_visible=all 1s.
//   - A frame_tick in the same cycle is discarded.
//  frame_tick during SCAN/REPORT: ignored, since the scan is always shorter than a frame.
//  Reset mid-scan: immediate clear to the reset values; no partial credit survives.
// STRUCTURE
//  game_pkg: coin_fsm_t enum {IDLE,SCAN,REPORT}; coin_pos_t struct {logic [9:0] x,y;};
//   COORD_W=10 constant.
//  Sub-module coin_table_rom: synchronous ROM, NUM_COINS entries.
//   Ports: Clk, addr -> coin_pos_t.
//   Contents set by a localparam array holding the maze coin layout.
// TESTING
//  1 Reset=0 mid-scan -> all outputs at reset values next cycle; coin_visible=16'hFFFF.
//  2 Player centred on coin 3, Ball_Size=4 -> after one frame_tick, coin_visible[3]=0.
//    C_up=1 for exactly the following frame; counter sees one increment.
//  3 Player overlapping coins 5 and 6 in one frame -> both cleared in the same scan.
//    C_up=1 for two consecutive frames, then 0.
//  4 Player parked on coin 3 for 10 frames -> only one credit (coin already collected).
//  5 Edge distance: |dx| = Ball_Size+COIN_HALF-1 gives a hit; |dx| = Ball_Size+COIN_HALF
//    gives no hit. Check at X=0 and X=639 for signed-difference correctness.
//  6 Collect all 16 coins -> all_collected=1.
//    clr asserted together with frame_tick -> coin_visible=all 1s, pending=0, C_up=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the coin collector.
package game_pkg;

  localparam int COORD_W = 10;
  localparam int DIFF_W  = COORD_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} coin_fsm_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coin_pos_t;

  // |a-b| on zero-extended coordinates, so X=0 vs a small coin X does not wrap.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
  endfunction

endpackage

// File: rtl/coin_table_rom.sv
// Synchronous ROM holding the maze coin layout; one-cycle read latency.
module coin_table_rom
  import game_pkg::*;
#(
  parameter int NUM_COINS = 16
)(
  input  logic      Clk,
  input  logic [4:0] addr,
  output coin_pos_t pos
);

  // {x, y} per coin; entries past NUM_COINS are never addressed.
  localparam logic [2*COORD_W-1:0] LAYOUT [32] = '{
    {10'd40,  10'd40 }, {10'd120, 10'd40 }, {10'd200, 10'd40 }, {10'd280, 10'd40 },
    {10'd360, 10'd40 }, {10'd300, 10'd200}, {10'd310, 10'd200}, {10'd7,   10'd300},
    {10'd632, 10'd300}, {10'd100, 10'd400}, {10'd200, 10'd400}, {10'd300, 10'd400},
    {10'd400, 10'd400}, {10'd500, 10'd400}, {10'd560, 10'd100}, {10'd600, 10'd460},
    {10'd40,  10'd250}, {10'd80,  10'd250}, {10'd120, 10'd250}, {10'd160, 10'd250},
    {10'd400, 10'd250}, {10'd440, 10'd250}, {10'd480, 10'd250}, {10'd520, 10'd250},
    {10'd40,  10'd460}, {10'd120, 10'd460}, {10'd200, 10'd460}, {10'd280, 10'd460},
    {10'd440, 10'd120}, {10'd480, 10'd160}, {10'd520, 10'd200}, {10'd600, 10'd40 }
  };

  coin_pos_t pos_q;

  // Registered table lookup.
  always_ff @(posedge Clk) begin
    pos_q <= (int'(addr) < NUM_COINS) ? coin_pos_t'(LAYOUT[addr]) : '0;
  end

  assign pos = pos_q;

endmodule

// File: rtl/coin_collector.sv
// Per-frame coin scanner: clears coins under the player and meters out credits
// to the score counter as one C_up frame per collected coin.
module coin_collector
  import game_pkg::*;
#(
  parameter int NUM_COINS = 16,
  parameter int COIN_HALF = 4,
  parameter int PEND_W    = 4
)(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 clr,
  input  logic [COORD_W-1:0]   Ball_X,
  input  logic [COORD_W-1:0]   Ball_Y,
  input  logic [COORD_W-1:0]   Ball_Size,
  output logic                 C_up,
  output logic [NUM_COINS-1:0] coin_visible,
  output logic                 all_collected,
  output logic                 busy
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam logic [IDX_W:0]   END_CNT  = (IDX_W+1)'(NUM_COINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);

  logic [1:0]           fsync_q, fsync_d;
  logic                 fprev_q, fprev_d;
  coin_fsm_t            state_q, state_d;
  logic [IDX_W:0]       idx_q, idx_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [COORD_W-1:0]   bx_q, bx_d, by_q, by_d, bs_q, bs_d;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic                 c_up_q, c_up_d;
  logic [NUM_COINS-1:0] vis_q, vis_d;
  logic                 allc_q, allc_d;
  logic                 busy_q, busy_d;

  logic                 frame_tick;
  logic [DIFF_W-1:0]    lim;
  logic                 hit;
  coin_pos_t            rom_pos;

  coin_table_rom #(.NUM_COINS(NUM_COINS)) u_rom (
    .Clk  (Clk),
    .addr (5'(idx_q)),
    .pos  (rom_pos)
  );

  // Tick detect and overlap test against the coin read out last cycle.
  always_comb begin
    frame_tick = fsync_q[1] & ~fprev_q;
    lim        = DIFF_W'(bs_q) + DIFF_W'(COIN_HALF);
    hit        = rd_vld_q && vis_q[rd_idx_q]
              && (abs_diff(bx_q, rom_pos.x) < lim)
              && (abs_diff(by_q, rom_pos.y) < lim);
  end

  // Next-state: frame sync, scan FSM, credit bookkeeping; clr overrides all.
  always_comb begin
    fsync_d  = {fsync_q[0], frame_clk};
    fprev_d  = fsync_q[1];
    state_d  = state_q;
    idx_d    = idx_q;
    rd_vld_d = 1'b0;
    rd_idx_d = rd_idx_q;
    bx_d     = bx_q;
    by_d     = by_q;
    bs_d     = bs_q;
    pend_d   = pend_q;
    c_up_d   = c_up_q;
    vis_d    = vis_q;
    allc_d   = allc_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          // The counter just sampled C_up on this edge, so that credit is spent.
          pend_d  = pend_q - PEND_W'(c_up_q);
          c_up_d  = 1'b0;
          bx_d    = Ball_X;
          by_d    = Ball_Y;
          bs_d    = Ball_Size;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q < END_CNT) begin
          rd_vld_d = 1'b1;
          rd_idx_d = IDX_W'(idx_q);
          idx_d    = idx_q + 1'b1;
        end
        if (hit) begin
          vis_d[rd_idx_q] = 1'b0;
          if (pend_q != {PEND_W{1'b1}}) pend_d = pend_q + 1'b1;
        end
        if (rd_vld_q && rd_idx_q == LAST_IDX) state_d = REPORT;
      end
      REPORT: begin
        c_up_d  = (pend_q != '0);
        allc_d  = (vis_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d  = IDLE;
      idx_d    = '0;
      rd_vld_d = 1'b0;
      pend_d   = '0;
      c_up_d   = 1'b0;
      vis_d    = '1;
      allc_d   = 1'b0;
    end

    busy_d = (state_d == SCAN);
  end

  // State registers; reset restores a full board with no credits.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync_q  <= '0;
      fprev_q  <= 1'b0;
      state_q  <= IDLE;
      idx_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      bs_q     <= '0;
      pend_q   <= '0;
      c_up_q   <= 1'b0;
      vis_q    <= '1;
      allc_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fsync_q  <= fsync_d;
      fprev_q  <= fprev_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      bs_q     <= bs_d;
      pend_q   <= pend_d;
      c_up_q   <= c_up_d;
      vis_q    <= vis_d;
      allc_q   <= allc_d;
      busy_q   <= busy_d;
    end
  end

  assign C_up          = c_up_q;
  assign coin_visible  = vis_q;
  assign all_collected = allc_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_coin_collector.sv
// Directed frames with hand-computed results; a monitor checks each scan result.
module tb_coin_collector;

  logic        Clk, Reset, frame_clk, clr;
  logic [9:0]  Ball_X, Ball_Y, Ball_Size;
  logic        C_up, all_collected, busy;
  logic [15:0] coin_visible;

  typedef struct {
    int          id;
    logic        c;
    logic [15:0] v;
    logic        a;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0, fails = 0, score = 0, fno = 0;

  coin_collector #(.NUM_COINS(16), .COIN_HALF(4), .PEND_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clr(clr),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y), .Ball_Size(Ball_Size),
    .C_up(C_up), .coin_visible(coin_visible),
    .all_collected(all_collected), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Score counter model: samples C_up on each frame_clk rising edge.
  always @(posedge frame_clk) if (C_up === 1'b1) score++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: each completed scan (busy falling, not by reset) pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge busy);
      if (Reset === 1'b1) begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        if (exp_q.size() == 0) check("unexpected_scan", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("f%0d_C_up", e.id), {31'd0, C_up}, {31'd0, e.c});
          check($sformatf("f%0d_visible", e.id), {16'd0, coin_visible}, {16'd0, e.v});
          check($sformatf("f%0d_all_collected", e.id), {31'd0, all_collected}, {31'd0, e.a});
        end
      end
    end
  end

  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s,
                       input logic ec, input logic [15:0] ev, input logic ea);
    exp_t e;
    fno++;
    e.id = fno; e.c = ec; e.v = ev; e.a = ea;
    exp_q.push_back(e);
    @(negedge Clk);
    Ball_X = x; Ball_Y = y; Ball_Size = s;
    frame_clk = 1'b1;
    repeat (20) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (20) @(negedge Clk);
  endtask

  task automatic far(input logic ec, input logic [15:0] ev, input logic ea);
    frame(10'd900, 10'd1000, 10'd1, ec, ev, ea);
  endtask

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; clr = 1'b0;
    Ball_X = 10'd900; Ball_Y = 10'd1000; Ball_Size = 10'd1;
    repeat (3) @(negedge Clk);
    check("rst_C_up", {31'd0, C_up}, 32'd0);
    check("rst_visible", {16'd0, coin_visible}, 32'hFFFF);
    check("rst_all_collected", {31'd0, all_collected}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    // Reset in the middle of a scan that has already hit coin 3.
    Ball_X = 10'd280; Ball_Y = 10'd40; Ball_Size = 10'd4;
    frame_clk = 1'b1;
    for (int n = 0; n < 20 && busy !== 1'b1; n++) @(negedge Clk);
    check("midscan_busy_seen", {31'd0, busy}, 32'd1);
    repeat (8) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("midrst_C_up", {31'd0, C_up}, 32'd0);
    check("midrst_visible", {16'd0, coin_visible}, 32'hFFFF);
    check("midrst_all_collected", {31'd0, all_collected}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    far(1'b0, 16'hFFFF, 1'b0);

    // Parked on coin 3 for 10 frames: one credit only.
    frame(10'd280, 10'd40, 10'd4, 1'b1, 16'hFFF7, 1'b0);
    for (int i = 0; i < 9; i++) frame(10'd280, 10'd40, 10'd4, 1'b0, 16'hFFF7, 1'b0);
    check("score_after_parked", score, 32'd1);

    // Coins 5 and 6 together: two credits over two frames.
    frame(10'd305, 10'd200, 10'd4, 1'b1, 16'hFF97, 1'b0);
    far(1'b1, 16'hFF97, 1'b0);
    far(1'b0, 16'hFF97, 1'b0);
    far(1'b0, 16'hFF97, 1'b0);
    check("score_after_double", score, 32'd3);

    // Distance boundaries, including the screen edges.
    frame(10'd0,   10'd300, 10'd3, 1'b0, 16'hFF97, 1'b0);
    frame(10'd0,   10'd300, 10'd4, 1'b1, 16'hFF17, 1'b0);
    frame(10'd639, 10'd300, 10'd3, 1'b0, 16'hFF17, 1'b0);
    frame(10'd639, 10'd300, 10'd4, 1'b1, 16'hFE17, 1'b0);
    frame(10'd560, 10'd92,  10'd4, 1'b0, 16'hFE17, 1'b0);
    frame(10'd560, 10'd93,  10'd4, 1'b1, 16'hBE17, 1'b0);

    // Sweep up the remaining coins.
    frame(10'd40,  10'd40,  10'd4, 1'b1, 16'hBE16, 1'b0);
    frame(10'd120, 10'd40,  10'd4, 1'b1, 16'hBE14, 1'b0);
    frame(10'd200, 10'd40,  10'd4, 1'b1, 16'hBE10, 1'b0);
    frame(10'd360, 10'd40,  10'd4, 1'b1, 16'hBE00, 1'b0);
    frame(10'd100, 10'd400, 10'd4, 1'b1, 16'hBC00, 1'b0);
    frame(10'd200, 10'd400, 10'd4, 1'b1, 16'hB800, 1'b0);
    frame(10'd300, 10'd400, 10'd4, 1'b1, 16'hB000, 1'b0);
    frame(10'd400, 10'd400, 10'd4, 1'b1, 16'hA000, 1'b0);
    frame(10'd500, 10'd400, 10'd4, 1'b1, 16'h8000, 1'b0);
    frame(10'd600, 10'd460, 10'd4, 1'b1, 16'h0000, 1'b1);

    // clr held across a frame tick while a credit is pending.
    @(negedge Clk);
    clr = 1'b1;
    Ball_X = 10'd900; Ball_Y = 10'd1000; Ball_Size = 10'd1;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (8) @(negedge Clk);
    clr = 1'b0;
    @(negedge Clk);
    check("clr_C_up", {31'd0, C_up}, 32'd0);
    check("clr_visible", {16'd0, coin_visible}, 32'hFFFF);
    check("clr_all_collected", {31'd0, all_collected}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (10) @(negedge Clk);
    far(1'b0, 16'hFFFF, 1'b0);
    check("score_final", score, 32'd15);

    check("scans_outstanding", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
